// File: rtl/sr_ff_monitor.sv
// Response checker for an SR flip-flop: reference model, compare, event counters, first-error capture.
// Optional build macro SR_MON_STRICT_INVALID_EN makes a sampled S=1,R=1 an error in its own right.
module sr_ff_monitor #(
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          dut_rst,
   input  logic          S,
   input  logic          R,
   input  logic          Q,
   input  logic          Qbar,
   output logic          err,
   output logic [1:0]    err_code,
   output logic [CW-1:0] first_err_cyc,
   output logic [CW-1:0] set_cnt,
   output logic [CW-1:0] clr_cnt,
   output logic [CW-1:0] inv_cnt,
   output logic [CW-1:0] mis_cnt,
   output logic [CW-1:0] cyc_cnt
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {
      ST_UNK = 2'd0,
      ST_K0  = 2'd1,
      ST_K1  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   cmp_en_c;
   logic   exp_q_c;
   logic   q_mis_c;
   logic   qb_err_c;
   logic   strict_inv_c;
   logic   any_err_c;
   logic [1:0] code_c;
   logic   set_ev_c;
   logic   clr_ev_c;
   logic   inv_ev_c;

   // Model state register; frozen while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  state <= ST_UNK;
      else if (en) state <= state_nxt;
   end

   // Model next state: DUT reset dominates, 11 loses knowledge of Q
   always_comb begin
      state_nxt = state;
      if (dut_rst) begin
         state_nxt = ST_K0;
      end else begin
         case ({S, R})
            2'b10:   state_nxt = ST_K1;
            2'b01:   state_nxt = ST_K0;
            2'b11:   state_nxt = ST_UNK;
            default: state_nxt = state;
         endcase
      end
   end

   // Expectation derived from the pre-update state
   always_comb begin
      cmp_en_c = 1'b0;
      exp_q_c  = 1'b0;
      case (state)
         ST_K0:   cmp_en_c = 1'b1;
         ST_K1:   begin cmp_en_c = 1'b1; exp_q_c = 1'b1; end
         default: cmp_en_c = 1'b0;
      endcase
   end

   assign set_ev_c = !dut_rst &&  S && !R;
   assign clr_ev_c = !dut_rst && !S &&  R;
   assign inv_ev_c = !dut_rst &&  S &&  R;

`ifdef SR_MON_STRICT_INVALID_EN
   assign strict_inv_c = inv_ev_c;
`else
   assign strict_inv_c = 1'b0;
`endif

   assign q_mis_c   = cmp_en_c && (Q != exp_q_c);
   assign qb_err_c  = cmp_en_c && (Qbar == Q);
   assign any_err_c = q_mis_c || qb_err_c || strict_inv_c;

   // Q mismatch outranks a Qbar error, which outranks strict invalid
   always_comb begin
      code_c = 2'b11;
      if (q_mis_c)       code_c = 2'b01;
      else if (qb_err_c) code_c = 2'b10;
   end

   // Counters and sticky first-error capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err           <= 1'b0;
         err_code      <= 2'b00;
         first_err_cyc <= '0;
         set_cnt       <= '0;
         clr_cnt       <= '0;
         inv_cnt       <= '0;
         mis_cnt       <= '0;
         cyc_cnt       <= '0;
      end else if (en) begin
         cyc_cnt <= cyc_cnt + CW'(1);
         if (set_ev_c  && set_cnt != CNT_MAX) set_cnt <= set_cnt + CW'(1);
         if (clr_ev_c  && clr_cnt != CNT_MAX) clr_cnt <= clr_cnt + CW'(1);
         if (inv_ev_c  && inv_cnt != CNT_MAX) inv_cnt <= inv_cnt + CW'(1);
         if (any_err_c && mis_cnt != CNT_MAX) mis_cnt <= mis_cnt + CW'(1);
         if (any_err_c && !err) begin
            err           <= 1'b1;
            err_code      <= code_c;
            first_err_cyc <= cyc_cnt;
         end
      end
   end

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Bench for sr_ff_monitor: vector table, directed corner sequences and random stimulus vs. a reference model.
module tb_sr_ff_monitor;

`ifdef SR_MON_STRICT_INVALID_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, en, dut_rst, S, R, Q, Qbar;

   logic        err16, err4;
   logic [1:0]  code16, code4;
   logic [15:0] first16, set16, clr16, inv16, mis16, cyc16;
   logic [3:0]  first4, set4, clr4, inv4, mis4, cyc4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sr_ff_monitor #(.CW(16)) u_dut16 (
      .clk(clk), .reset(reset), .en(en), .dut_rst(dut_rst), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
      .err(err16), .err_code(code16), .first_err_cyc(first16), .set_cnt(set16),
      .clr_cnt(clr16), .inv_cnt(inv16), .mis_cnt(mis16), .cyc_cnt(cyc16));

   sr_ff_monitor #(.CW(4)) u_dut4 (
      .clk(clk), .reset(reset), .en(en), .dut_rst(dut_rst), .S(S), .R(R), .Q(Q), .Qbar(Qbar),
      .err(err4), .err_code(code4), .first_err_cyc(first4), .set_cnt(set4),
      .clr_cnt(clr4), .inv_cnt(inv4), .mis_cnt(mis4), .cyc_cnt(cyc4));

   // Reference model: unbounded event tallies, reduced to each instance's width on compare
   int     m_exp;   // -1 = Q unknown, else expected Q level
   longint n_set, n_clr, n_inv, n_mis, n_cyc, n_first;
   bit     m_err;
   int     m_code;

   function automatic longint lim(input longint x, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (x > mx) ? mx : x;
   endfunction

   function automatic longint wrapv(input longint x, input int w);
      return x % (longint'(1) << w);
   endfunction

   task automatic model_reset();
      m_exp = -1; n_set = 0; n_clr = 0; n_inv = 0; n_mis = 0; n_cyc = 0; n_first = 0;
      m_err = 1'b0; m_code = 0;
   endtask

   task automatic model_edge(input bit e, input bit dr, input bit s, input bit r, input bit q, input bit qb);
      bit qm, qbe, inv;
      if (!e) return;
      qm  = (m_exp >= 0) && (int'(q) != m_exp);
      qbe = (m_exp >= 0) && (qb == q);
      inv = STRICT && !dr && s && r;
      if (!dr) begin
         if (s && !r) n_set++;
         if (!s && r) n_clr++;
         if (s && r)  n_inv++;
      end
      if (qm || qbe || inv) begin
         n_mis++;
         if (!m_err) begin
            m_err = 1'b1;
            m_code = qm ? 1 : (qbe ? 2 : 3);
            n_first = n_cyc;
         end
      end
      n_cyc++;
      if (dr)            m_exp = 0;
      else if (s && !r)  m_exp = 1;
      else if (!s && r)  m_exp = 0;
      else if (s && r)   m_exp = -1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("err16",   longint'(err16),   longint'(m_err));
      chk("code16",  longint'(code16),  longint'(m_code));
      chk("first16", longint'(first16), wrapv(n_first, 16));
      chk("set16",   longint'(set16),   lim(n_set, 16));
      chk("clr16",   longint'(clr16),   lim(n_clr, 16));
      chk("inv16",   longint'(inv16),   lim(n_inv, 16));
      chk("mis16",   longint'(mis16),   lim(n_mis, 16));
      chk("cyc16",   longint'(cyc16),   wrapv(n_cyc, 16));
      chk("err4",    longint'(err4),    longint'(m_err));
      chk("code4",   longint'(code4),   longint'(m_code));
      chk("first4",  longint'(first4),  wrapv(n_first, 4));
      chk("set4",    longint'(set4),    lim(n_set, 4));
      chk("clr4",    longint'(clr4),    lim(n_clr, 4));
      chk("inv4",    longint'(inv4),    lim(n_inv, 4));
      chk("mis4",    longint'(mis4),    lim(n_mis, 4));
      chk("cyc4",    longint'(cyc4),    wrapv(n_cyc, 4));
   endtask

   // One clock: drive in the low phase, let the model see the same edge, check on the falling edge
   task automatic step(input bit e, input bit dr, input bit s, input bit r, input bit q, input bit qb);
      en = e; dut_rst = dr; S = s; R = r; Q = q; Qbar = qb;
      @(posedge clk);
      model_edge(e, dr, s, r, q, qb);
      @(negedge clk);
      check_model();
   endtask

   // Asynchronous reset pulse in the low phase; outputs must clear without a clock edge
   task automatic pulse_reset();
      en = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_model();
      reset = 1'b1;
   endtask

   function automatic bit good_q();
      return (m_exp < 0) ? 1'($urandom_range(0, 1)) : 1'(m_exp);
   endfunction

   typedef struct {
      bit en, dr, s, r, q, qb;
      bit e_err;
      int e_code, e_set, e_clr, e_mis;
   } vec_t;

   vec_t tbl[8];

   initial begin
      bit q;
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1, 0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1, 1, 0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 2, 1, 0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 2, 1, 1};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 1, 1};

      reset = 1'b0; en = 1'b0; dut_rst = 1'b0; S = 1'b0; R = 1'b0; Q = 1'b0; Qbar = 1'b1;
      model_reset();
      #1;
      check_model();
      @(negedge clk);
      reset = 1'b1;

      // Reset/set/clear/hold with a correct flop, then a Qbar fault in K1
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].en, tbl[i].dr, tbl[i].s, tbl[i].r, tbl[i].q, tbl[i].qb);
         chk("tbl_err",  longint'(err16), longint'(tbl[i].e_err));
         chk("tbl_code", longint'(code16), longint'(tbl[i].e_code));
         chk("tbl_set",  longint'(set16), longint'(tbl[i].e_set));
         chk("tbl_clr",  longint'(clr16), longint'(tbl[i].e_clr));
         chk("tbl_mis",  longint'(mis16), longint'(tbl[i].e_mis));
      end
      chk("tbl_first", longint'(first16), 6);

      // Q stuck at 0 through a set
      pulse_reset();
      step(1, 1, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 1);
      chk("stuck_no_err_yet", longint'(err16), 0);
      step(1, 0, 0, 0, 0, 1);
      chk("stuck_err",   longint'(err16), 1);
      chk("stuck_code",  longint'(code16), 1);
      chk("stuck_first", longint'(first16), 2);

      // Two invalid cycles then arbitrary Q
      pulse_reset();
      step(1, 1, 0, 0, 0, 1);
      step(1, 0, 1, 1, 0, 1);
      step(1, 0, 1, 1, 1, 1);
      step(1, 0, 0, 0, 1, 0);
      chk("inv_cnt",  longint'(inv16), 2);
      chk("inv_err",  longint'(err16), STRICT ? 1 : 0);
      chk("inv_code", longint'(code16), STRICT ? 3 : 0);
      chk("inv_mis",  longint'(mis16), STRICT ? 2 : 0);

      // Saturation with a 3-cycle enable gap in the middle
      pulse_reset();
      step(1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         q = good_q();
         step(1, 0, 1, 0, q, !q);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("gap_cyc16", longint'(cyc16), 11);
         chk("gap_set16", longint'(set16), 10);
      end
      for (int i = 0; i < 10; i++) begin
         q = good_q();
         step(1, 0, 1, 0, q, !q);
      end
      chk("sat_set4",  longint'(set4), 15);
      chk("sat_set16", longint'(set16), 20);
      chk("sat_cyc4",  longint'(cyc4), 5);
      chk("sat_err",   longint'(err16), 0);

      // Mid-run asynchronous reset clears everything immediately
      pulse_reset();
      chk("arst_set", longint'(set16), 0);
      chk("arst_cyc", longint'(cyc16), 0);

      // No false errors right after reset release while the model is unknown
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("unk_no_err", longint'(err16), 0);

      // Random stimulus with occasional faults, enable gaps and resets
      for (int i = 0; i < 4000; i++) begin
         bit e, dr, s, r, qb;
         if ($urandom_range(0, 399) == 0) pulse_reset();
         e  = ($urandom_range(0, 9) != 0);
         dr = ($urandom_range(0, 19) == 0);
         s  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         q  = good_q();
         if ($urandom_range(0, 29) == 0) q = !q;
         qb = !q;
         if ($urandom_range(0, 39) == 0) qb = q;
         step(e, dr, s, r, q, qb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_ff_monitor.md
# sr_ff_monitor

Synthesizable response checker for the `sr_ff` flip-flop: it observes the stimulus driven into an SR flop and the flop's `Q`/`Qbar` outputs. It runs a cycle-accurate reference model, flags mismatches, counts set/clear/invalid events, and latches the cycle of the first error. It sits beside the DUT in benches and on-chip self-test wrappers, so a testbench or BIST controller only has to read a pass/fail flag.

## Interface
Parameters:
- `CW`, 16: width of every event counter and of the cycle timestamp.

Ports:
- `clk`  input  1  sole clock; all sampling on the rising edge.
- `reset`  input  1  asynchronous, active-low reset of the monitor.
- `en`  input  1  monitor enable; when 0, no model update, compare, count or timestamp advance.
- `dut_rst`  input  1  the DUT's own reset as driven to it (active-high, synchronous in the DUT).
- `S`, `R`  input  1 each  stimulus as driven to the DUT.
- `Q`, `Qbar`  input  1 each  DUT outputs.
- `err`  output  1  sticky error flag.
- `err_code`  output  2  cause of the first error: 01 = Q mismatch, 10 = Qbar not equal to ~Q, 11 = strict invalid (see Configuration).
- `first_err_cyc`  output  CW  value of `cyc_cnt` when `err` first rose.
- `set_cnt`, `clr_cnt`, `inv_cnt`, `mis_cnt`  output  CW each  saturating event counters.
- `cyc_cnt`  output  CW  enabled-cycle counter, wraps modulo 2^CW.

## Operation
- Model FSM states: UNK (expected Q unknown), K0 (expects 0), K1 (expects 1). Reset state is UNK.
- Transitions, evaluated on each enabled edge from the sampled `dut_rst`/`S`/`R`:
  - `dut_rst`=1 -> K0, overriding S/R.
  - S=1, R=0 -> K1.
  - S=0, R=1 -> K0.
  - S=0, R=0 -> hold the current state.
  - S=1, R=1 -> UNK.
- The compare uses the state held *before* the current edge's update. That state is the expectation for the Q the DUT produced on the previous edge.
- Compare runs only when the pre-update state is K0 or K1:
  - Q != expected -> mismatch.
  - Qbar != ~Q -> Qbar error.
- No compare is performed in UNK.
- Counters:
  - `set_cnt` increments on S=1,R=0.
  - `clr_cnt` increments on S=0,R=1.
  - `inv_cnt` increments on S=1,R=1.
  - `mis_cnt` increments on each cycle with any mismatch or Qbar error.
  - All four saturate at 2^CW-1.
  - `dut_rst`=1 cycles increment none of the stimulus counters.
- Errors:
  - `err` sets on the first detected error and stays set until `reset`.
  - On that same edge, `err_code` and `first_err_cyc` load.
  - Later errors change only `mis_cnt`.
  - If both a Q mismatch and a Qbar error occur in one cycle, `err_code`=01.
- `en`=0 freezes every register. The model is not updated, so the compare on the next enabled edge uses the frozen state.

## Timing
- Reset (`reset` low, asynchronous): `err`=0, `err_code`=00, `first_err_cyc`=0, all counters 0, FSM=UNK. All outputs are registered.
- Error latency: a DUT output error present before edge k+1 (from stimulus sampled at edge k) is visible on `err` after edge k+1, i.e. 1 cycle.
- The first compare after monitor reset occurs no earlier than the second enabled edge that follows a defining stimulus or `dut_rst`.
- Releasing `reset` mid-run restarts in UNK. There are no false errors until a set, clear or `dut_rst` is seen.
- `cyc_cnt` is the pre-increment value on the latching edge. The cycle-0 error therefore records 0.

## Configuration
- `SR_MON_STRICT_INVALID_EN`:
  - Defined: sampling S=1,R=1 is itself an error. `mis_cnt` increments and, if `err`=0, `err`=1 with `err_code`=11.
  - Not defined: S=1,R=1 only increments `inv_cnt` and moves the FSM to UNK. `err_code` 11 is never produced.

## Test plan
- Reset sequence: `dut_rst`=1 for 1 cycle, then S=1,R=0, then S=0,R=1, then 00, with a correct DUT -> `err`=0, `set_cnt`=1, `clr_cnt`=1, `mis_cnt`=0.
- Forced fault: Q held at 0 through a set -> `err`=1 one cycle after the set's effect edge, `err_code`=01, `first_err_cyc` equals that cycle's `cyc_cnt`.
- Qbar fault: Q=1, Qbar=1 while in K1 -> `err_code`=10, `mis_cnt`=1.
- Invalid 11 for 2 cycles, then arbitrary Q -> `inv_cnt`=2, no error without the macro. With the macro, `err_code`=11 and `mis_cnt`=2.
- Saturation with CW=4: 20 consecutive sets -> `set_cnt`=15. `en`=0 for 3 cycles mid-run -> `cyc_cnt` unchanged across them. Async `reset` pulse mid-cycle -> all outputs 0 immediately.
